// File: rtl/icache_fetch_if.sv
// Bundles the cpu fetch port, the memory fill port and the statistics of icache_fetch.
// slave is the cache's view; master is the view of the cpu/memory environment.
interface icache_fetch_if;
    logic [31:0] cpu_addr;
    logic        cpu_req;
    logic [31:0] cpu_data;
    logic        cpu_ready;
    logic        flush;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    modport slave (
        input  cpu_addr, cpu_req, flush, mem_data, mem_valid,
        output cpu_data, cpu_ready, mem_addr, mem_rd, hit_cnt, miss_cnt
    );

    modport master (
        output cpu_addr, cpu_req, flush, mem_data, mem_valid,
        input  cpu_data, cpu_ready, mem_addr, mem_rd, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache: zero-wait hits, whole-line fill on a miss,
// flush support and saturating hit/miss statistics.
module icache_fetch #(
    parameter int INDEX_BITS = 4,
    parameter int WORD_BITS  = 2
) (
    input  logic         clk,
    input  logic         rst,
    icache_fetch_if.slave bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << WORD_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - WORD_BITS - 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [LINES-1:0]        valid_d;
    logic [TAG_BITS-1:0]     tag_arr  [LINES];
    logic [31:0]             data_arr [LINES*WORDS];
    logic [TAG_BITS-1:0]     fill_tag;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic [WORD_BITS-1:0]    fill_cnt;
    logic [WORD_BITS-1:0]    fill_cnt_nx;
    logic                    flush_pend;

    logic [TAG_BITS-1:0]     req_tag;
    logic [INDEX_BITS-1:0]   req_idx;
    logic [WORD_BITS-1:0]    req_word;
    logic                    hit;
    logic                    miss;
    logic                    accept;
    logic                    last;
    logic                    unused_byte_bits;

    assign req_tag  = bus.cpu_addr[31 -: TAG_BITS];
    assign req_idx  = bus.cpu_addr[INDEX_BITS+WORD_BITS+1 : WORD_BITS+2];
    assign req_word = bus.cpu_addr[WORD_BITS+1 : 2];
    assign unused_byte_bits = ^bus.cpu_addr[1:0];

    assign hit    = (state == IDLE) && bus.cpu_req && valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign miss   = (state == IDLE) && bus.cpu_req && !hit;
    assign accept = (state == FILL) && bus.mem_valid;
    assign last   = (fill_cnt == {WORD_BITS{1'b1}});
    assign fill_cnt_nx = fill_cnt + 1'b1;

    assign bus.cpu_ready = hit;
    assign bus.cpu_data  = hit ? data_arr[{req_idx, req_word}] : 32'd0;

    // A flush seen at any point of a fill keeps the completing line invalid.
    always_comb begin
        valid_d = bus.flush ? '0 : valid;
        if (accept && last && !flush_pend && !bus.flush)
            valid_d[fill_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            valid        <= '0;
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= 32'd0;
            bus.hit_cnt  <= 32'd0;
            bus.miss_cnt <= 32'd0;
            flush_pend   <= 1'b0;
            fill_cnt     <= '0;
            fill_tag     <= '0;
            fill_idx     <= '0;
        end else begin
            valid <= valid_d;
            if (hit && bus.hit_cnt != 32'hFFFF_FFFF)
                bus.hit_cnt <= bus.hit_cnt + 32'd1;
            case (state)
                IDLE: begin
                    if (miss) begin
                        state        <= FILL;
                        fill_cnt     <= '0;
                        fill_tag     <= req_tag;
                        fill_idx     <= req_idx;
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= {req_tag, req_idx, {WORD_BITS{1'b0}}, 2'b00};
                        if (bus.miss_cnt != 32'hFFFF_FFFF)
                            bus.miss_cnt <= bus.miss_cnt + 32'd1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        fill_cnt     <= fill_cnt_nx;
                        bus.mem_addr <= {fill_tag, fill_idx, fill_cnt_nx, 2'b00};
                        if (last) begin
                            state      <= IDLE;
                            bus.mem_rd <= 1'b0;
                            flush_pend <= 1'b0;
                        end else if (bus.flush) begin
                            flush_pend <= 1'b1;
                        end
                    end else if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Arrays carry no reset; the valid bits alone decide whether their contents are used.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_arr[{fill_idx, fill_cnt}] <= bus.mem_data;
            if (last)
                tag_arr[fill_idx] <= fill_tag;
        end
    end
endmodule

// File: tb/tb_icache_fetch.sv
// Directed and randomized fetch sequences for icache_fetch, checked against a line-level cache model.
module tb_icache_fetch;
    logic clk;
    logic rst;
    icache_fetch_if bus ();

    icache_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.mem_data = memf(bus.mem_addr);

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    int unsigned m_hit   = 0;
    int unsigned m_miss  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hits(input logic [31:0] a);
        return m_valid[(a >> 4) & 15] && (m_tag[(a >> 4) & 15] == (a >> 8));
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a request until it is served; lat = idle cycles before each fill word is accepted.
    task automatic fetch(input logic [31:0] addr, input int lat, input int flush_w, input int nhold);
        logic [31:0] base;
        bit flushed;
        int fw;
        fw = flush_w;
        base = addr & 32'hFFFF_FFF0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        for (int att = 0; att < 3; att++) begin
            if (m_hits(addr)) begin
                for (int h = 0; h < nhold; h++) begin
                    bus.mem_valid = 1'($urandom % 2);
                    @(negedge clk);
                    chk("hit_ready", {31'd0, bus.cpu_ready}, 32'd1);
                    chk("hit_data", bus.cpu_data, memf(addr));
                    chk("hit_no_rd", {31'd0, bus.mem_rd}, 32'd0);
                    step();
                    m_hit++;
                end
                bus.cpu_req   = 1'b0;
                bus.mem_valid = 1'b0;
                chk("hit_cnt", bus.hit_cnt, m_hit);
                chk("miss_cnt", bus.miss_cnt, m_miss);
                return;
            end
            bus.mem_valid = 1'($urandom % 2);
            @(negedge clk);
            chk("miss_ready", {31'd0, bus.cpu_ready}, 32'd0);
            chk("miss_data", bus.cpu_data, 32'd0);
            step();
            m_miss++;
            flushed = 1'b0;
            for (int w = 0; w < 4; w++) begin
                for (int k = 0; k <= lat; k++) begin
                    bus.mem_valid = (k == lat);
                    bus.flush     = (w == fw) && (k == 0);
                    @(negedge clk);
                    chk("fill_rd", {31'd0, bus.mem_rd}, 32'd1);
                    chk("fill_addr", bus.mem_addr, base + 32'(4 * w));
                    chk("fill_ready", {31'd0, bus.cpu_ready}, 32'd0);
                    step();
                    if (bus.flush) begin
                        flushed = 1'b1;
                        m_clear();
                    end
                    bus.flush = 1'b0;
                end
            end
            bus.mem_valid = 1'b0;
            fw = -1;
            if (!flushed) begin
                m_valid[(addr >> 4) & 15] = 1'b1;
                m_tag[(addr >> 4) & 15]   = addr >> 8;
            end
        end
        chk("fetch_served", 32'd0, 32'd1);
        bus.cpu_req = 1'b0;
    endtask

    task automatic flush_idle();
        bus.cpu_req = 1'b0;
        bus.flush   = 1'b1;
        @(negedge clk);
        chk("flush_idle_ready", {31'd0, bus.cpu_ready}, 32'd0);
        step();
        bus.flush = 1'b0;
        m_clear();
    endtask

    initial begin
        logic [31:0] a;
        rst           = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = 32'd0;
        bus.flush     = 1'b0;
        bus.mem_valid = 1'b0;
        m_clear();
        #3;
        chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_ready", {31'd0, bus.cpu_ready}, 32'd0);
        chk("rst_data", bus.cpu_data, 32'd0);
        chk("rst_hit_cnt", bus.hit_cnt, 32'd0);
        chk("rst_miss_cnt", bus.miss_cnt, 32'd0);
        step();
        step();
        #2 rst = 1'b1;
        step();

        fetch(32'h40, 0, -1, 1);
        fetch(32'h48, 0, -1, 3);
        fetch(32'h440, 0, -1, 1);
        fetch(32'h40, 0, -1, 1);
        chk("conflict_miss_cnt", bus.miss_cnt, 32'd3);
        fetch(32'h440, 0, -1, 1);
        fetch(32'h40, 0, 2, 1);

        // Flush together with a hit: hit still served, line gone next cycle.
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h48;
        bus.flush    = 1'b1;
        @(negedge clk);
        chk("flush_hit_ready", {31'd0, bus.cpu_ready}, 32'd1);
        chk("flush_hit_data", bus.cpu_data, memf(32'h48));
        step();
        bus.flush = 1'b0;
        m_hit++;
        m_clear();
        fetch(32'h48, 0, -1, 1);

        flush_idle();
        fetch(32'h40, 3, -1, 1);

        for (int it = 0; it < 40; it++) begin
            a = ($urandom % 4) << 8 | ($urandom % 16) << 4 | ($urandom % 4) << 2;
            if ($urandom % 8 == 0) flush_idle();
            fetch(a, int'($urandom % 3), ($urandom % 6 == 0) ? int'($urandom % 4) : -1, 1 + int'($urandom % 2));
        end

        // Reset in the middle of a fill; 0x1230 is never used by the random phase.
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 32'h1230;
        bus.mem_valid = 1'b1;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("midrst_ready", {31'd0, bus.cpu_ready}, 32'd0);
        chk("midrst_hit_cnt", bus.hit_cnt, 32'd0);
        chk("midrst_miss_cnt", bus.miss_cnt, 32'd0);
        bus.cpu_req   = 1'b0;
        bus.mem_valid = 1'b0;
        m_clear();
        m_hit  = 0;
        m_miss = 0;
        #3 rst = 1'b1;
        step();
        fetch(32'h40, 0, -1, 1);
        chk("post_rst_miss_cnt", bus.miss_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
